// File: rtl/text_pkg.sv
// Shared constants and type encodings for the character-RAM write arbiter.
// Contents: screen geometry, RAM address width, fill code, terminal control
// codes, FSM state encoding, round-robin owner encoding and cursor operations.
package text_pkg;

    localparam int unsigned COLS   = 100;  // 800 px / 8 px glyph
    localparam int unsigned ROWS   = 30;   // 480 px / 16 px glyph
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned CELLS  = COLS * ROWS;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    // Requester that completed the most recent handshake.
    typedef enum logic [0:0] {RrStream, RrDirect} rr_e;

    typedef enum logic [2:0] {
        CurNone,
        CurAdvance,
        CurCr,
        CurLf,
        CurBs
    } cur_op_e;

endpackage

// File: rtl/text_cursor.sv
// Terminal cursor: holds column/row, applies advance/CR/LF/BS with wrap-around
// (no scrolling) and presents the linear cell address row*COLS+col.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   home       : force cursor to 0/0 (takes priority over op)
//   op         : cursor operation for this cycle
//   col, row   : current cursor position
//   addr       : linear RAM address of the current cell
module text_cursor
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              home,
    input  cur_op_e           op,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] row_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Bottom row wraps to the top; the renderer has no scroll support.
    assign row_inc = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (home) begin
            col_d = '0;
            row_d = '0;
        end else begin
            unique case (op)
                CurAdvance: begin
                    if (col_q == COL_W'(COLS - 1)) begin
                        col_d = '0;
                        row_d = row_inc;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                CurCr: col_d = '0;
                CurLf: row_d = row_inc;
                CurBs: if (col_q != '0) col_d = col_q - COL_W'(1);
                default: ;
            endcase
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

endmodule

// File: rtl/text_buffer_arbiter.sv
// Sole owner of the character-RAM write port for the text renderer.
// Sweeps the whole screen with BLANK after reset and on request, then
// round-robins between a terminal-style character stream and direct cell
// writes. All RAM outputs are registered: an accept in cycle N writes in N+1.
// Ports:
//   MemoryClk, nRST          : clock, asynchronous active-low reset
//   clear_req                : pulse, full clear plus cursor home
//   s_valid/s_data/s_ready   : character stream handshake
//   d_valid/d_addr/d_data/d_ready : direct cell write handshake
//   ram_we/ram_addr/ram_wdata: character RAM write port
//   cursor_col, cursor_row   : stream cursor position
//   busy                     : clear sweep in progress
module text_buffer_arbiter
    import text_pkg::*;
(
    input  logic              MemoryClk,
    input  logic              nRST,
    input  logic              clear_req,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [7:0]        d_data,
    output logic              d_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy
);

    state_e             state_q, state_d;
    rr_e                rr_q, rr_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic               we_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [7:0]         wdata_d;
    logic               s_acc, d_acc;
    logic               cur_home;
    cur_op_e            cur_op;
    logic [ADDR_W-1:0]  cur_addr;

    text_cursor u_cursor (
        .clk   (MemoryClk),
        .rst_n (nRST),
        .home  (cur_home),
        .op    (cur_op),
        .col   (cursor_col),
        .row   (cursor_row),
        .addr  (cur_addr)
    );

    always_ff @(posedge MemoryClk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StClear;
            rr_q      <= RrDirect;
            clr_cnt_q <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            clr_cnt_q <= clr_cnt_d;
            ram_we    <= we_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
        end
    end

    assign s_acc = s_valid & s_ready;
    assign d_acc = d_valid & d_ready;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        clr_cnt_d = clr_cnt_q;
        we_d      = 1'b0;
        addr_d    = ram_addr;
        wdata_d   = ram_wdata;
        cur_home  = 1'b0;
        cur_op    = CurNone;
        unique case (state_q)
            StClear: begin
                we_d      = 1'b1;
                addr_d    = clr_cnt_q;
                wdata_d   = BLANK;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(CELLS - 1)) state_d = StIdle;
            end
            StIdle: begin
                if (clear_req) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                    cur_home  = 1'b1;
                end else if (s_acc) begin
                    rr_d = RrStream;
                    unique case (s_data)
                        CH_CR: cur_op = CurCr;
                        CH_LF: cur_op = CurLf;
                        CH_BS: begin
                            // Rubs out the cell to the left; at column 0 it is a no-op.
                            if (cursor_col != '0) begin
                                cur_op  = CurBs;
                                we_d    = 1'b1;
                                addr_d  = cur_addr - ADDR_W'(1);
                                wdata_d = BLANK;
                            end
                        end
                        CH_FF: begin
                            state_d   = StClear;
                            clr_cnt_d = '0;
                            cur_home  = 1'b1;
                        end
                        default: begin
                            if (s_data >= 8'h20 && s_data <= 8'h7E) begin
                                cur_op  = CurAdvance;
                                we_d    = 1'b1;
                                addr_d  = cur_addr;
                                wdata_d = s_data;
                            end
                        end
                    endcase
                end else if (d_acc) begin
                    rr_d = RrDirect;
                    // Out-of-range cells are accepted but dropped.
                    if (d_addr < ADDR_W'(CELLS)) begin
                        we_d    = 1'b1;
                        addr_d  = d_addr;
                        wdata_d = d_data;
                    end
                end
            end
            default: state_d = StClear;
        endcase
    end

    // When both requesters are valid, the one that did not win last time goes.
    always_comb begin
        busy    = (state_q == StClear);
        s_ready = (state_q == StIdle) & ~clear_req & (~d_valid | (rr_q == RrDirect));
        d_ready = (state_q == StIdle) & ~clear_req & (~s_valid | (rr_q == RrStream));
    end

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Scoreboard bench for text_buffer_arbiter: stimulus pushes expected RAM
// writes into a queue; a monitor pops and compares on every ram_we cycle.
module tb_text_buffer_arbiter;

    logic        MemoryClk = 1'b0;
    logic        nRST;
    logic        clear_req;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        d_valid;
    logic [11:0] d_addr;
    logic [7:0]  d_data;
    logic        d_ready;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [19:0] exp_q[$];

    text_buffer_arbiter dut (
        .MemoryClk  (MemoryClk),
        .nRST       (nRST),
        .clear_req  (clear_req),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .d_valid    (d_valid),
        .d_addr     (d_addr),
        .d_data     (d_data),
        .d_ready    (d_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 MemoryClk = ~MemoryClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented RAM write must match the next expected one.
    always @(negedge MemoryClk) begin
        if (nRST === 1'b1 && ram_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                         ram_addr, ram_wdata);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({ram_addr, ram_wdata} !== e) begin
                    n_bad++;
                    $display("FAIL ram_write: got addr %0d data %0h expected addr %0d data %0h",
                             ram_addr, ram_wdata, e[19:8], e[7:0]);
                end
            end
        end
    end

    task automatic push_wr(input int a, input logic [7:0] d);
        logic [11:0] a12;
        a12 = 12'(a);
        exp_q.push_back({a12, d});
    endtask

    task automatic push_sweep();
        for (int a = 0; a < 3000; a++) push_wr(a, 8'h20);
    endtask

    task automatic send_s(input logic [7:0] ch);
        bit ok;
        ok = 0;
        s_valid = 1'b1;
        s_data  = ch;
        for (int i = 0; i < 50; i++) begin
            @(negedge MemoryClk);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("s_handshake_timeout", 32'd0, 32'd1);
        @(posedge MemoryClk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_d(input logic [11:0] a, input logic [7:0] d);
        bit ok;
        ok = 0;
        d_valid = 1'b1;
        d_addr  = a;
        d_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge MemoryClk);
            if (d_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("d_handshake_timeout", 32'd0, 32'd1);
        @(posedge MemoryClk);
        #1;
        d_valid = 1'b0;
    endtask

    task automatic wait_sweep(input string name);
        bit rdy_seen;
        rdy_seen = 0;
        @(negedge MemoryClk);
        check({name, "_busy_start"}, 32'(busy), 32'd1);
        for (int i = 0; i < 3100; i++) begin
            if (!busy) break;
            if (s_ready || d_ready) rdy_seen = 1;
            @(negedge MemoryClk);
        end
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        check({name, "_ready_during_sweep"}, 32'(rdy_seen), 32'd0);
        check({name, "_s_ready_after"}, 32'(s_ready), 32'd1);
        check({name, "_cursor"}, {25'd0, cursor_row, cursor_col}, 32'd0);
        @(posedge MemoryClk);
        #1;
    endtask

    initial begin
        nRST      = 1'b0;
        clear_req = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        d_valid   = 1'b0;
        d_addr    = '0;
        d_data    = 8'h00;
        repeat (3) @(negedge MemoryClk);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_cursor", {25'd0, cursor_row, cursor_col}, 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_readies", {30'd0, s_ready, d_ready}, 32'd0);

        // Power-on sweep.
        push_sweep();
        @(posedge MemoryClk);
        #1;
        nRST = 1'b1;
        wait_sweep("init_sweep");

        // "AB" back to back, then an unknown code that must be ignored.
        push_wr(0, 8'h41);
        push_wr(1, 8'h42);
        send_s(8'h41);
        send_s(8'h42);
        check("ab_cursor", {25'd0, cursor_row, cursor_col}, {25'd0, 5'd0, 7'd2});
        send_s(8'h01);
        check("unknown_code_cursor", {25'd0, cursor_row, cursor_col}, {25'd0, 5'd0, 7'd2});

        // CR + 29 LF + 99 printables to reach col 99 row 29.
        send_s(8'h0D);
        check("cr_cursor", {25'd0, cursor_row, cursor_col}, 32'd0);
        for (int i = 0; i < 29; i++) send_s(8'h0A);
        check("lf_cursor", {25'd0, cursor_row, cursor_col}, {25'd0, 5'd29, 7'd0});
        for (int i = 0; i < 99; i++) begin
            push_wr(2900 + i, 8'h2E);
            send_s(8'h2E);
        end
        check("last_cell_cursor", {25'd0, cursor_row, cursor_col}, {25'd0, 5'd29, 7'd99});
        push_wr(2999, 8'h41);
        send_s(8'h41);
        check("wrap_cursor", {25'd0, cursor_row, cursor_col}, 32'd0);

        // Backspace, and backspace at column 0.
        push_wr(0, 8'h41);
        send_s(8'h41);
        push_wr(0, 8'h20);
        send_s(8'h08);
        check("bs_cursor", {25'd0, cursor_row, cursor_col}, 32'd0);
        send_s(8'h08);
        check("bs_col0_cursor", {25'd0, cursor_row, cursor_col}, 32'd0);

        // Both requesters held: last winner was stream, so direct goes first.
        push_wr(5, 8'h5A);
        push_wr(0, 8'h43);
        push_wr(5, 8'h5A);
        push_wr(1, 8'h43);
        push_wr(5, 8'h5A);
        push_wr(2, 8'h43);
        s_valid = 1'b1;
        s_data  = 8'h43;
        d_valid = 1'b1;
        d_addr  = 12'd5;
        d_data  = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            @(negedge MemoryClk);
            check("rr_grant", {30'd0, s_ready, d_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge MemoryClk);
            #1;
        end
        s_valid = 1'b0;
        d_valid = 1'b0;
        check("rr_cursor", {25'd0, cursor_row, cursor_col}, {25'd0, 5'd0, 7'd3});

        // Direct writes at the last legal cell and one past it.
        push_wr(2999, 8'h7E);
        send_d(12'd2999, 8'h7E);
        send_d(12'd3000, 8'h11);
        repeat (3) @(posedge MemoryClk);
        #1;
        check("queue_drained_direct", 32'(exp_q.size()), 32'd0);

        // Form feed triggers a full sweep.
        push_sweep();
        send_s(8'h0C);
        wait_sweep("ff_sweep");

        // clear_req blocks a concurrent handshake.
        push_wr(0, 8'h5A);
        send_s(8'h5A);
        check("z_cursor", {25'd0, cursor_row, cursor_col}, {25'd0, 5'd0, 7'd1});
        push_sweep();
        clear_req = 1'b1;
        s_valid   = 1'b1;
        s_data    = 8'h41;
        d_valid   = 1'b1;
        d_addr    = 12'd7;
        @(negedge MemoryClk);
        check("clear_req_readies", {30'd0, s_ready, d_ready}, 32'd0);
        @(posedge MemoryClk);
        #1;
        clear_req = 1'b0;
        s_valid   = 1'b0;
        d_valid   = 1'b0;
        wait_sweep("req_sweep");

        repeat (4) @(posedge MemoryClk);
        #1;
        check("queue_drained_end", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
